vram_arbiter: RTL and testbench

//  Shares one single-port synchronous cell-map RAM between VGA scanout and game logic.

---
 rtl/vram_arbiter.sv | 159 +++++++++++++++
 tb/tb_vram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous cell-map RAM between VGA scanout and game
// logic. Scanout reads one cell per cell-wide run of pixels. A bulk clear fills
// the whole map with CLR_VAL. A simple request/ack writer stores single cells.
// Per-cycle priority is scanout > clear > writer.
//
// Ports
//   clk, reset           pixel clock; asynchronous active-high reset
//   inside_video         active-area flag from the timing generator
//   x_position           pixel column (valid while inside_video)
//   y_position           pixel row (valid while inside_video)
//   wr_req/addr/data     writer request; addr/data held stable until wr_ack
//   wr_ack               one-cycle pulse when the request is consumed
//   clr_start            pulse that starts a bulk clear (ignored while clearing)
//   clr_busy             bulk clear in progress
//   ram_addr/we/wdata    RAM control, combinational
//   ram_rdata            RAM read data, valid one cycle after the address
//   pix_cell             cell value for the pixel presented last cycle
//   pix_valid            inside_video delayed by one cycle
// ----------------------------------------------------------------------------

module vram_arbiter #(
    parameter int unsigned CELL_W_LOG2 = 5,
    parameter int unsigned CELL_H_LOG2 = 5,
    parameter int unsigned COLS        = 20,
    parameter int unsigned ROWS        = 15,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned CLR_VAL     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inside_video,
    input  logic [9:0]        x_position,
    input  logic [8:0]        y_position,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_cell,
    output logic              pix_valid
);

    localparam int unsigned NCELLS = COLS * ROWS;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              scan_q;
    logic              valid_q;
    logic [DATA_W-1:0] cell_q;

    logic              scan_slot;
    logic [31:0]       scan_addr_full;
    logic              wr_in_range;
    logic              last_cell;
    logic              we;
    logic              ack;

    // A scan slot is the first pixel of every cell-wide run in the active area.
    assign scan_slot = inside_video && (x_position[CELL_W_LOG2-1:0] == '0);

    // Row*COLS is formed at 32 bits so the product never wraps before truncation.
    assign scan_addr_full = 32'(y_position >> CELL_H_LOG2) * 32'(COLS)
                          + 32'(x_position >> CELL_W_LOG2);

    assign wr_in_range = 32'(wr_addr) < NCELLS;
    assign last_cell   = 32'(ptr_q) == (NCELLS - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we      = 1'b0;
        ack     = 1'b0;

        if (scan_slot) begin
            addr_d = scan_addr_full[ADDR_W-1:0];
        end else begin
            case (state_q)
                StClear: begin
                    we      = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = DATA_W'(CLR_VAL);
                    if (last_cell) begin
                        ptr_d   = '0;
                        state_d = StIdle;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: begin
                    // Out-of-range requests are acked and dropped without a write.
                    if (wr_req) begin
                        ack = 1'b1;
                        if (wr_in_range) begin
                            we      = 1'b1;
                            addr_d  = wr_addr;
                            wdata_d = wr_data;
                        end
                    end
                end
            endcase
        end

        // A clear request may coincide with a writer grant; the clear starts next cycle.
        if ((state_q == StIdle) && clr_start) begin
            state_d = StClear;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            scan_q  <= 1'b0;
            valid_q <= 1'b0;
            cell_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            scan_q  <= scan_slot;
            valid_q <= inside_video;
            cell_q  <= pix_cell;
        end
    end

    // RAM data for last cycle's scan slot is passed straight through so the cell
    // lines up with pix_valid; between slots the captured value is held.
    assign pix_cell  = scan_q ? ram_rdata : cell_q;
    assign pix_valid = valid_q;
    assign clr_busy  = (state_q == StClear);

    assign ram_addr  = reset ? '0 : addr_d;
    assign ram_we    = we && !reset;
    assign ram_wdata = wdata_d;
    assign wr_ack    = ack && !reset;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inside_video = 1'b0;
    logic [9:0] x_position = '0;
    logic [8:0] y_position = '0;
    logic       wr_req = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ack;
    logic       clr_start = 1'b0;
    logic       clr_busy;
    logic [8:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic [3:0] pix_cell;
    logic       pix_valid;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inside_video (inside_video),
        .x_position   (x_position),
        .y_position   (y_position),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .pix_cell     (pix_cell),
        .pix_valid    (pix_valid)
    );

    always #20 clk = ~clk;

    // Single-port synchronous RAM, read-before-write.
    logic [3:0] ram_mem [512];
    initial begin
        for (int i = 0; i < 512; i++) ram_mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mem [512];
    bit m_clearing   = 1'b0;
    int m_ptr        = 0;
    int m_last       = 0;
    bit m_scan_prev  = 1'b0;
    int m_scan_val   = 0;
    int m_cell       = 0;
    bit m_valid_prev = 1'b0;
    initial for (int i = 0; i < 512; i++) m_mem[i] = 0;

    always @(negedge clk) begin
        bit scan, e_we, e_ack;
        int saddr, e_addr, e_wd, e_cell;
        if (reset) begin
            chk("rst_ack", wr_ack, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_busy", clr_busy, 0);
            chk("rst_valid", pix_valid, 0);
            chk("rst_cell", pix_cell, 0);
            m_clearing   = 1'b0;
            m_ptr        = 0;
            m_last       = 0;
            m_scan_prev  = 1'b0;
            m_cell       = 0;
            m_valid_prev = 1'b0;
        end else begin
            scan  = inside_video && (x_position % 32 == 0);
            saddr = ((int'(y_position) / 32) * 20 + int'(x_position) / 32) % 512;
            e_we  = 1'b0;
            e_ack = 1'b0;
            e_wd  = 0;
            e_addr = m_last;
            if (scan) begin
                e_addr = saddr;
            end else if (m_clearing) begin
                e_we = 1'b1; e_addr = m_ptr; e_wd = 0;
            end else if (wr_req) begin
                e_ack = 1'b1;
                if (wr_addr < 300) begin
                    e_we = 1'b1; e_addr = wr_addr; e_wd = wr_data;
                end
            end
            e_cell = m_scan_prev ? m_scan_val : m_cell;

            chk("m_ack", wr_ack, e_ack);
            chk("m_we", ram_we, e_we);
            chk("m_addr", ram_addr, e_addr);
            if (e_we) chk("m_wdata", ram_wdata, e_wd);
            chk("m_busy", clr_busy, m_clearing);
            chk("m_valid", pix_valid, m_valid_prev);
            chk("m_cell", pix_cell, e_cell);

            m_cell       = e_cell;
            m_scan_prev  = scan;
            m_scan_val   = m_mem[saddr];
            m_valid_prev = inside_video;
            m_last       = e_addr;
            if (e_we) m_mem[e_addr] = e_wd;
            if (m_clearing) begin
                if (!scan) begin
                    if (m_ptr == 299) begin
                        m_clearing = 1'b0; m_ptr = 0;
                    end else begin
                        m_ptr++;
                    end
                end
            end else if (clr_start) begin
                m_clearing = 1'b1; m_ptr = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        int n;
        n = 0;
        wr_req = 1'b1; wr_addr = 9'(a); wr_data = 4'(d);
        #1;
        while (!wr_ack && n < 50) begin tick(); #1; n++; end
        chk("wr_grant_wait", int'(n < 50), 1);
        tick();
        wr_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, nwr, nack, nexp, bad, nz, n;
        repeat (3) tick();
        chk("lit_rst_valid", pix_valid, 0);
        reset = 1'b0;
        tick();

        do_write(0, 3);
        do_write(1, 5);

        // Scan timing and collision with the x=32 scan slot
        inside_video = 1'b1; y_position = 9'd0;
        wr_addr = 9'd7; wr_data = 4'd9;
        for (int x = 0; x < 64; x++) begin
            x_position = 10'(x);
            wr_req = (x == 32 || x == 33);
            #1;
            if (x == 0)  chk("t1_addr0", ram_addr, 0);
            if (x == 1)  begin chk("t1_pix0", pix_cell, 3); chk("t1_valid", pix_valid, 1); end
            if (x == 31) chk("t1_pix31", pix_cell, 3);
            if (x == 32) begin
                chk("t1_addr1", ram_addr, 1);
                chk("t3_noack", wr_ack, 0);
                chk("t1_pix_hold", pix_cell, 3);
            end
            if (x == 33) begin
                chk("t3_ack", wr_ack, 1);
                chk("t3_we", ram_we, 1);
                chk("t3_addr", ram_addr, 7);
                chk("t3_wdata", ram_wdata, 9);
                chk("t1_pix32", pix_cell, 5);
            end
            tick();
        end
        wr_req = 1'b0; inside_video = 1'b0; x_position = '0;
        tick();
        chk("t3_mem7", ram_mem[7], 9);

        // Addressing
        inside_video = 1'b1; y_position = 9'd32; x_position = 10'd0; #1;
        chk("t2_addr20", ram_addr, 20); tick();
        y_position = 9'd479; x_position = 10'd608; #1;
        chk("t2_addr299", ram_addr, 299); tick();
        x_position = 10'd639; #1;
        chk("t2_hold_we", ram_we, 0);
        chk("t2_hold_addr", ram_addr, 299); tick();
        y_position = 9'd0; x_position = 10'd224; #1;
        chk("t3_rb_addr", ram_addr, 7); tick();
        inside_video = 1'b0; x_position = '0; #1;
        chk("t3_rb_cell", pix_cell, 9); tick();

        // Out-of-range write
        wr_req = 1'b1; wr_addr = 9'd300; wr_data = 4'd15; #1;
        chk("t5_ack", wr_ack, 1);
        chk("t5_we", ram_we, 0);
        tick(); wr_req = 1'b0; tick();
        chk("t5_mem300", ram_mem[300], 0);
        chk("t5_mem7", ram_mem[7], 9);

        // Bulk clear with a held (out-of-range) writer request
        wr_req = 1'b1; wr_addr = 9'd300; clr_start = 1'b1; #1;
        chk("t4_same_cycle_ack", wr_ack, 1);
        tick(); clr_start = 1'b0; #1;
        chk("t4_busy", clr_busy, 1);
        inside_video = 1'b1; y_position = '0;
        cyc = 0; nwr = 0; nack = 0; nexp = 0; bad = 0;
        while (clr_busy && cyc < 2000) begin
            x_position = 10'(cyc % 64); #1;
            if (ram_we) begin
                if (ram_addr != 9'(nexp)) bad++;
                nexp++; nwr++;
            end
            if (wr_ack) nack++;
            tick(); cyc++;
        end
        chk("t4_done", clr_busy, 0);
        chk("t4_writes", nwr, 300);
        chk("t4_seq_err", bad, 0);
        chk("t4_ack_busy", nack, 0);
        chk("t4_min_cycles", int'(cyc >= 300), 1);
        inside_video = 1'b0; x_position = '0; #1;
        chk("t4_ack_after", wr_ack, 1);
        tick(); wr_req = 1'b0; tick();
        nz = 0;
        for (int i = 0; i < 300; i++) if (ram_mem[i] != 4'd0) nz++;
        chk("t4_nonzero_cells", nz, 0);

        // Reset mid-clear
        do_write(200, 7);
        inside_video = 1'b1; y_position = '0; x_position = 10'd1;
        clr_start = 1'b1; tick(); clr_start = 1'b0; #1;
        n = 0;
        while (!(ram_we && ram_addr == 9'd150) && n < 400) begin tick(); #1; n++; end
        chk("t6_reach150", int'(n < 400), 1);
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("t6_busy", clr_busy, 0);
        chk("t6_we", ram_we, 0);
        chk("t6_valid", pix_valid, 0);
        tick(); tick();
        reset = 1'b0; inside_video = 1'b0; x_position = '0; #1;
        chk("t6_busy_after", clr_busy, 0);
        chk("t6_mem200", ram_mem[200], 7);
        chk("t6_mem150", ram_mem[150], 0);
        tick();
        clr_start = 1'b1; tick(); clr_start = 1'b0; #1;
        chk("t6_restart_we", ram_we, 1);
        chk("t6_restart_addr", ram_addr, 0);
        n = 0;
        while (clr_busy && n < 1000) begin tick(); n++; end
        chk("t6_done", clr_busy, 0);
        chk("t6_mem200_clr", ram_mem[200], 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
